// File: rtl/mff_pkg.sv
// Package for the multimode flip-flop register.
// Holds the two-bit mode encodings shared by the register and its bench.
package mff_pkg;

    typedef enum logic [1:0] {
        MFF_MODE_HOLD   = 2'b00,
        MFF_MODE_LOAD   = 2'b01,
        MFF_MODE_TOGGLE = 2'b10,
        MFF_MODE_SHIFT  = 2'b11
    } mff_mode_e;

endpackage

// File: rtl/mff_tcell.sv
// Single-bit T flip-flop with asynchronous active-low reset.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; q takes RESET_VAL
//   t     - toggle request; q inverts on the edge when t=1
//   q     - stored bit
module mff_tcell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/multimode_ff_reg.sv
// WIDTH-bit register built from T flip-flops, with runtime-selected HOLD, LOAD,
// TOGGLE (masked) or SHIFT behaviour. Every mode is expressed as a per-bit
// toggle vector t so that Q_next = Q ^ t.
// Ports:
//   CLK     - clock, rising edge
//   reset   - asynchronous active-low reset (Q=RESET_VAL, changed=0)
//   en      - clock enable; 0 forces HOLD
//   mode    - 00 HOLD, 01 LOAD, 10 TOGGLE, 11 SHIFT
//   D       - load data (LOAD) or toggle mask (TOGGLE)
//   ser_in  - serial input entering bit 0 in SHIFT
//   Q       - register contents
//   ser_out - Q[WIDTH-1]
//   changed - 1 for the cycle after an edge that altered Q
//   par     - even parity of Q, registered (only with MFF_PARITY_EN defined)
// Configuration macro: MFF_PARITY_EN adds the par output and its register.
module multimode_ff_reg
    import mff_pkg::*;
#(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out,
    output logic             changed
`ifdef MFF_PARITY_EN
    ,
    output logic             par
`endif
);

    logic [WIDTH-1:0] t;
    logic             changed_q;

    always_comb begin
        t = '0;
        if (en) begin
            case (mode)
                MFF_MODE_HOLD:   t = '0;
                MFF_MODE_LOAD:   t = Q ^ D;
                MFF_MODE_TOGGLE: t = D;
                MFF_MODE_SHIFT:  t = Q ^ {Q[WIDTH-2:0], ser_in};
                default:         t = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mff_tcell #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk   (CLK),
            .rst_n (reset),
            .t     (t[i]),
            .q     (Q[i])
        );
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |t;
        end
    end

    assign changed = changed_q;
    assign ser_out = Q[WIDTH-1];

`ifdef MFF_PARITY_EN
    logic par_q;

    // Registered from the next-state value so par lines up with Q.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= ^(Q ^ t);
        end
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb_multimode_ff_reg.sv
module tb_multimode_ff_reg;
    import mff_pkg::*;

    logic       CLK;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] D;
    logic       ser_in;
    logic [7:0] Q;
    logic       ser_out;
    logic       changed;
`ifdef MFF_PARITY_EN
    logic       par;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_ch;
    } vec_t;

    vec_t vecs[20];

    multimode_ff_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .D       (D),
        .ser_in  (ser_in),
        .Q       (Q),
        .ser_out (ser_out),
        .changed (changed)
`ifdef MFF_PARITY_EN
        ,
        .par     (par)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (reset === 1'b1 && en === 1'b1) begin
            assert (!$isunknown(mode)) else $error("mode is X while enabled");
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] d,
                        input logic s);
        @(negedge CLK);
        en = e; mode = m; D = d; ser_in = s;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] prev_q;

        vecs[0]  = '{1'b1, MFF_MODE_LOAD,   8'hA5, 1'b0, 8'hA5, 1'b1};
        vecs[1]  = '{1'b1, MFF_MODE_TOGGLE, 8'h0F, 1'b0, 8'hAA, 1'b1};
        vecs[2]  = '{1'b1, MFF_MODE_TOGGLE, 8'h0F, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{1'b1, MFF_MODE_TOGGLE, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, MFF_MODE_LOAD,   8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[5]  = '{1'b1, MFF_MODE_LOAD,   8'h81, 1'b0, 8'h81, 1'b1};
        vecs[6]  = '{1'b1, MFF_MODE_SHIFT,  8'h00, 1'b1, 8'h03, 1'b1};
        vecs[7]  = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h06, 1'b1};
        vecs[8]  = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h0C, 1'b1};
        vecs[9]  = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h18, 1'b1};
        vecs[10] = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h30, 1'b1};
        vecs[11] = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h60, 1'b1};
        vecs[12] = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'hC0, 1'b1};
        vecs[13] = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h80, 1'b1};
        vecs[14] = '{1'b1, MFF_MODE_SHIFT,  8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[15] = '{1'b1, MFF_MODE_HOLD,   8'hFF, 1'b1, 8'h00, 1'b0};
        vecs[16] = '{1'b1, MFF_MODE_LOAD,   8'h5A, 1'b0, 8'h5A, 1'b1};
        vecs[17] = '{1'b0, MFF_MODE_LOAD,   8'hFF, 1'b1, 8'h5A, 1'b0};
        vecs[18] = '{1'b0, MFF_MODE_TOGGLE, 8'hFF, 1'b1, 8'h5A, 1'b0};
        vecs[19] = '{1'b0, MFF_MODE_SHIFT,  8'hFF, 1'b1, 8'h5A, 1'b0};

        // Reset held with a LOAD of FF pending and the clock running.
        reset = 1'b0; en = 1'b1; mode = MFF_MODE_LOAD; D = 8'hFF; ser_in = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset Q", Q, 8'h00);
        check("reset changed", {7'd0, changed}, 8'h00);
        check("reset ser_out", {7'd0, ser_out}, 8'h00);

        @(negedge CLK);
        reset = 1'b1; en = 1'b0;

        prev_q = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            en = vecs[i].en; mode = vecs[i].mode; D = vecs[i].d; ser_in = vecs[i].sin;
            #1;
            // ser_out must still show the pre-edge MSB.
            check($sformatf("vec%0d pre ser_out", i), {7'd0, ser_out}, {7'd0, prev_q[7]});
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d Q", i), Q, vecs[i].exp_q);
            check($sformatf("vec%0d changed", i), {7'd0, changed}, {7'd0, vecs[i].exp_ch});
            check($sformatf("vec%0d ser_out", i), {7'd0, ser_out}, {7'd0, vecs[i].exp_q[7]});
            prev_q = vecs[i].exp_q;
        end

        // Asynchronous reset between edges, with changed set beforehand.
        step(1'b1, MFF_MODE_TOGGLE, 8'hFF, 1'b0);
        check("pre-reset toggle Q", Q, 8'hA5);
        step(1'b1, MFF_MODE_TOGGLE, 8'hFF, 1'b0);
        check("pre-reset toggle back Q", Q, 8'h5A);
        check("pre-reset changed", {7'd0, changed}, 8'h01);
        @(negedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("async reset Q", Q, 8'h00);
        check("async reset changed", {7'd0, changed}, 8'h00);
        check("async reset ser_out", {7'd0, ser_out}, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        check("held reset Q", Q, 8'h00);
        check("held reset changed", {7'd0, changed}, 8'h00);
        @(negedge CLK);
        reset = 1'b1; en = 1'b0;

`ifdef MFF_PARITY_EN
        check("par reset", {7'd0, par}, 8'h00);
        step(1'b1, MFF_MODE_LOAD, 8'h07, 1'b0);
        check("par load 07", {7'd0, par}, 8'h01);
        step(1'b1, MFF_MODE_LOAD, 8'h03, 1'b0);
        check("par load 03", {7'd0, par}, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
